// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the read-channel arbiter.
// Imported by rr_arb2 and axi_rd_arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter returning the winning requester index.
// fixed_prio_i forces m0 to win ties; otherwise ties go to ~last_winner_i.
module rr_arb2
    import axi_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_winner_i,
    input  logic       fixed_prio_i,
    output logic       gnt_o
);

    always_comb begin
        gnt_o = 1'b0;
        unique case (1'b1)
            (&req_i):           gnt_o = ~fixed_prio_i & ~last_winner_i;
            (req_i == 2'b10):   gnt_o = 1'b1;
            default:            gnt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4 read arbiter: one burst in flight, grant held until rlast.
// Define RD_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round robin.
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              m0_axi_arvalid,
    output logic              m0_axi_arready,
    input  logic [ADDR_W-1:0] m0_axi_araddr,
    input  logic [LEN_W-1:0]  m0_axi_arlen,
    input  logic [2:0]        m0_axi_arsize,
    input  logic [1:0]        m0_axi_arburst,
    output logic              m0_axi_rvalid,
    input  logic              m0_axi_rready,
    output logic              m0_axi_rlast,
    output logic [DATA_W-1:0] m0_axi_rdata,
    output logic [1:0]        m0_axi_rresp,

    input  logic              m1_axi_arvalid,
    output logic              m1_axi_arready,
    input  logic [ADDR_W-1:0] m1_axi_araddr,
    input  logic [LEN_W-1:0]  m1_axi_arlen,
    input  logic [2:0]        m1_axi_arsize,
    input  logic [1:0]        m1_axi_arburst,
    output logic              m1_axi_rvalid,
    input  logic              m1_axi_rready,
    output logic              m1_axi_rlast,
    output logic [DATA_W-1:0] m1_axi_rdata,
    output logic [1:0]        m1_axi_rresp,

    output logic              s_axi_arvalid,
    input  logic              s_axi_arready,
    output logic [ADDR_W-1:0] s_axi_araddr,
    output logic [LEN_W-1:0]  s_axi_arlen,
    output logic [2:0]        s_axi_arsize,
    output logic [1:0]        s_axi_arburst,
    input  logic              s_axi_rvalid,
    output logic              s_axi_rready,
    input  logic              s_axi_rlast,
    input  logic [DATA_W-1:0] s_axi_rdata,
    input  logic [1:0]        s_axi_rresp
);

`ifdef RD_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_e state_q;
    logic       grant_q;
    logic       last_winner_q;
    logic       arb_gnt;

    rr_arb2 u_arb (
        .req_i         ({m1_axi_arvalid, m0_axi_arvalid}),
        .last_winner_i (last_winner_q),
        .fixed_prio_i  (FIXED_PRIO),
        .gnt_o         (arb_gnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_winner_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (m0_axi_arvalid | m1_axi_arvalid) begin
                        grant_q <= arb_gnt;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_axi_arvalid & s_axi_arready) begin
                        last_winner_q <= grant_q;
                        state_q       <= DATA;
                    end
                end
                DATA: begin
                    if (s_axi_rvalid & s_axi_rready & s_axi_rlast)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    logic in_addr;
    logic in_data;
    logic sel0_d;
    logic sel1_d;

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);
    assign sel0_d  = in_data & ~grant_q;
    assign sel1_d  = in_data &  grant_q;

    // AR valid depends only on the master's valid, never on s_axi_arready
    assign s_axi_arvalid = in_addr &
        (grant_q ? m1_axi_arvalid : m0_axi_arvalid);
    assign s_axi_araddr  = !in_addr ? '0 :
        (grant_q ? m1_axi_araddr : m0_axi_araddr);
    assign s_axi_arlen   = !in_addr ? '0 :
        (grant_q ? m1_axi_arlen : m0_axi_arlen);
    assign s_axi_arsize  = !in_addr ? '0 :
        (grant_q ? m1_axi_arsize : m0_axi_arsize);
    assign s_axi_arburst = !in_addr ? '0 :
        (grant_q ? m1_axi_arburst : m0_axi_arburst);

    assign m0_axi_arready = in_addr & ~grant_q & s_axi_arready;
    assign m1_axi_arready = in_addr &  grant_q & s_axi_arready;

    assign s_axi_rready = in_data &
        (grant_q ? m1_axi_rready : m0_axi_rready);

    assign m0_axi_rvalid = sel0_d & s_axi_rvalid;
    assign m0_axi_rlast  = sel0_d & s_axi_rlast;
    assign m0_axi_rdata  = sel0_d ? s_axi_rdata : '0;
    assign m0_axi_rresp  = sel0_d ? s_axi_rresp : AXI_RESP_OKAY;

    assign m1_axi_rvalid = sel1_d & s_axi_rvalid;
    assign m1_axi_rlast  = sel1_d & s_axi_rlast;
    assign m1_axi_rdata  = sel1_d ? s_axi_rdata : '0;
    assign m1_axi_rresp  = sel1_d ? s_axi_rresp : AXI_RESP_OKAY;

endmodule
